// File: rtl/diagnosis_trace_pkg.sv
// Shared definitions for the diagnosis trace serializer: flit format,
// packet length and the serializer FSM state encoding.
package diagnosis_trace_pkg;

    localparam int FLIT_WIDTH = 18;
    localparam int PKT_LEN    = 5;

    localparam logic [1:0] FLIT_PAYLOAD = 2'b00;
    localparam logic [1:0] FLIT_HEADER  = 2'b01;
    localparam logic [1:0] FLIT_LAST    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SRC,
        ST_ID,
        ST_TSH,
        ST_TSL
    } state_t;

    function automatic logic [FLIT_WIDTH-1:0] makeFlit(input logic [1:0]  flitType,
                                                       input logic [15:0] content);
        return {flitType, content};
    endfunction

endpackage

// File: rtl/diagnosis_event_fifo.sv
// Synchronous first-word-fall-through FIFO buffering captured events
// between the LUT strobe and the packet serializer.
module diagnosis_event_fifo #(
    parameter int WIDTH = 40,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_level;
    logic             w_doPush;
    logic             w_doPop;

    // A push into a full FIFO is only legal when a pop frees the slot in the same cycle.
    assign w_doPop  = i_pop && !o_empty;
    assign w_doPush = i_push && (!o_full || w_doPop);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_doPush) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_doPop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[r_rptr];
    assign o_full  = (r_level == (AW+1)'(DEPTH));
    assign o_empty = (r_level == '0);
    assign o_level = r_level;

endmodule

// File: rtl/diagnosis_trace_serializer.sv
// Buffers diagnosis events and serializes each one into a 5-flit lisnoc16
// trace packet, reporting dropped events in the ID flit.
module diagnosis_trace_serializer
    import diagnosis_trace_pkg::*;
#(
    parameter int          EV_ID_WIDTH     = 8,
    parameter int          TIMESTAMP_WIDTH = 32,
    parameter int          FIFO_DEPTH      = 4,
    parameter logic [15:0] CORE_ID         = 16'h0000,
    parameter logic [15:0] DEST_ID         = 16'h0000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          ev_valid,
    input  logic [EV_ID_WIDTH-1:0]        ev_id,
    input  logic [TIMESTAMP_WIDTH-1:0]    ev_time,
    output logic [FLIT_WIDTH-1:0]         dbgnoc_out_flit,
    output logic                          dbgnoc_out_valid,
    input  logic                          dbgnoc_out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_count
);

    localparam int ENTRY_W = EV_ID_WIDTH + TIMESTAMP_WIDTH;

    state_t                       r_state;
    state_t                       w_nextState;
    logic [FLIT_WIDTH-1:0]        r_flit;
    logic [FLIT_WIDTH-1:0]        w_nextFlit;
    logic                         r_valid;
    logic                         w_nextValid;
    logic [EV_ID_WIDTH-1:0]       r_pktId;
    logic [TIMESTAMP_WIDTH-1:0]   r_pktTime;
    logic [7:0]                   r_dropCount;
    logic [7:0]                   w_idExt;
    logic [ENTRY_W-1:0]           w_fifoRdata;
    logic                         w_fifoFull;
    logic                         w_fifoEmpty;
    logic                         w_accept;
    logic                         w_pop;
    logic                         w_push;
    logic                         w_drop;
    logic                         w_evIn;
    logic                         w_dropLoad;

    assign w_evIn   = ev_valid && enable;
    assign w_accept = r_valid && dbgnoc_out_ready;
    assign w_push   = w_evIn && !(w_fifoFull && !w_pop);
    assign w_drop   = w_evIn && w_fifoFull && !w_pop;
    assign w_idExt  = 8'(r_pktId);

    diagnosis_event_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_wdata ({ev_id, ev_time}),
        .o_rdata (w_fifoRdata),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty),
        .o_level (fifo_level)
    );

    // The next flit is computed here so the registered output already shows it on the following cycle.
    always_comb begin
        w_nextState = r_state;
        w_nextFlit  = r_flit;
        w_nextValid = r_valid;
        w_pop       = 1'b0;
        w_dropLoad  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifoEmpty) begin
                    w_pop       = 1'b1;
                    w_nextState = ST_HDR;
                    w_nextFlit  = makeFlit(FLIT_HEADER, DEST_ID);
                    w_nextValid = 1'b1;
                end
            end
            ST_HDR: begin
                if (w_accept) begin
                    w_nextState = ST_SRC;
                    w_nextFlit  = makeFlit(FLIT_PAYLOAD, CORE_ID);
                end
            end
            ST_SRC: begin
                if (w_accept) begin
                    w_dropLoad  = 1'b1;
                    w_nextState = ST_ID;
                    w_nextFlit  = makeFlit(FLIT_PAYLOAD, {r_dropCount, w_idExt});
                end
            end
            ST_ID: begin
                if (w_accept) begin
                    w_nextState = ST_TSH;
                    w_nextFlit  = makeFlit(FLIT_PAYLOAD, r_pktTime[31:16]);
                end
            end
            ST_TSH: begin
                if (w_accept) begin
                    w_nextState = ST_TSL;
                    w_nextFlit  = makeFlit(FLIT_LAST, r_pktTime[15:0]);
                end
            end
            ST_TSL: begin
                if (w_accept) begin
                    if (!w_fifoEmpty) begin
                        w_pop       = 1'b1;
                        w_nextState = ST_HDR;
                        w_nextFlit  = makeFlit(FLIT_HEADER, DEST_ID);
                    end else begin
                        w_nextState = ST_IDLE;
                        w_nextFlit  = '0;
                        w_nextValid = 1'b0;
                    end
                end
            end
            default: begin
                w_nextState = ST_IDLE;
                w_nextFlit  = '0;
                w_nextValid = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_flit  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_flit  <= w_nextFlit;
            r_valid <= w_nextValid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_pop) begin
            r_pktId   <= w_fifoRdata[ENTRY_W-1:TIMESTAMP_WIDTH];
            r_pktTime <= w_fifoRdata[TIMESTAMP_WIDTH-1:0];
        end
    end

    // Reporting the count restarts it; a drop in the reporting cycle belongs to the next packet.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dropCount <= '0;
        end else if (w_dropLoad) begin
            r_dropCount <= w_drop ? 8'd1 : 8'd0;
        end else if (w_drop && (r_dropCount != 8'hFF)) begin
            r_dropCount <= r_dropCount + 8'd1;
        end
    end

    assign dbgnoc_out_flit  = r_flit;
    assign dbgnoc_out_valid = r_valid;
    assign drop_count       = r_dropCount;

endmodule

// File: tb/tb_diagnosis_trace_serializer.sv
// Self-checking bench for diagnosis_trace_serializer: directed scenarios plus
// a randomized phase, all compared against a queue-based transaction model.
module tb_diagnosis_trace_serializer;
    import diagnosis_trace_pkg::*;

    localparam logic [15:0] TB_DEST  = 16'h0010;
    localparam logic [15:0] TB_CORE  = 16'h0003;
    localparam int          TB_DEPTH = 4;

    typedef struct packed {
        logic [7:0]  id;
        logic [31:0] ts;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic        ev_valid;
    logic [7:0]  ev_id;
    logic [31:0] ev_time;
    logic [17:0] dbgnoc_out_flit;
    logic        dbgnoc_out_valid;
    logic        dbgnoc_out_ready;
    logic [2:0]  fifo_level;
    logic [7:0]  drop_count;

    int total = 0;
    int bad   = 0;

    ev_t        q[$];
    ev_t        pkt;
    bit         mActive;
    int         mIdx;
    int         mDrop;
    logic [7:0] mDropField;

    logic [17:0] singleReq [5] = '{18'h10010, 18'h00003, 18'h00005, 18'h01234, 18'h25678};
    logic [1:0]  typeReq   [5] = '{2'b01, 2'b00, 2'b00, 2'b00, 2'b10};

    always #5 clk = ~clk;

    diagnosis_trace_serializer #(
        .EV_ID_WIDTH     (8),
        .TIMESTAMP_WIDTH (32),
        .FIFO_DEPTH      (TB_DEPTH),
        .CORE_ID         (TB_CORE),
        .DEST_ID         (TB_DEST)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable           (enable),
        .ev_valid         (ev_valid),
        .ev_id            (ev_id),
        .ev_time          (ev_time),
        .dbgnoc_out_flit  (dbgnoc_out_flit),
        .dbgnoc_out_valid (dbgnoc_out_valid),
        .dbgnoc_out_ready (dbgnoc_out_ready),
        .fifo_level       (fifo_level),
        .drop_count       (drop_count)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h required=%h", tag, obs, req);
        end
    endtask

    function automatic logic [17:0] expFlit();
        case (mIdx)
            0:       return {2'b01, TB_DEST};
            1:       return {2'b00, TB_CORE};
            2:       return {2'b00, mDropField, pkt.id};
            3:       return {2'b00, pkt.ts[31:16]};
            default: return {2'b10, pkt.ts[15:0]};
        endcase
    endfunction

    // Advance the transaction model with the inputs present at this edge, then compare.
    task automatic cycle();
        bit evIn;
        bit accept;
        bit pop;
        bit drop;
        if (!rst) begin
            q.delete();
            mActive = 1'b0;
            mIdx    = 0;
            mDrop   = 0;
        end else begin
            evIn   = ev_valid && enable;
            accept = mActive && dbgnoc_out_ready;
            pop    = (q.size() > 0) && (!mActive || (accept && mIdx == PKT_LEN-1));
            drop   = evIn && (q.size() == TB_DEPTH) && !pop;
            if (accept && mIdx == 1) begin
                mDropField = 8'(mDrop);
                mDrop      = drop ? 1 : 0;
            end else if (drop && mDrop < 255) begin
                mDrop++;
            end
            if (pop) begin
                pkt     = q.pop_front();
                mActive = 1'b1;
                mIdx    = 0;
            end else if (accept) begin
                if (mIdx == PKT_LEN-1) mActive = 1'b0;
                else                   mIdx++;
            end
            if (evIn && !drop) q.push_back(ev_t'({ev_id, ev_time}));
        end
        @(posedge clk);
        #1;
        checkOutput("valid", 32'(dbgnoc_out_valid), 32'(mActive));
        if (mActive) checkOutput("flit", 32'(dbgnoc_out_flit), 32'(expFlit()));
        checkOutput("level", 32'(fifo_level), 32'(q.size()));
        checkOutput("dropCount", 32'(drop_count), 32'(mDrop));
    endtask

    task automatic applyStimulus(input logic [7:0] id, input logic [31:0] ts);
        ev_valid = 1'b1;
        ev_id    = id;
        ev_time  = ts;
        cycle();
        ev_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((mActive || q.size() > 0) && n < 300) begin
            cycle();
            n++;
        end
        checkOutput("drainTimeout", 32'(mActive || q.size() > 0), 32'd0);
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          n;
        logic [17:0] idReq;

        rst = 1'b0; enable = 1'b1; ev_valid = 1'b0; ev_id = '0; ev_time = '0;
        dbgnoc_out_ready = 1'b1;
        cycle();
        cycle();
        checkOutput("rstValid", 32'(dbgnoc_out_valid), 32'd0);
        checkOutput("rstFlit",  32'(dbgnoc_out_flit),  32'd0);
        checkOutput("rstLevel", 32'(fifo_level),       32'd0);
        checkOutput("rstDrop",  32'(drop_count),       32'd0);
        rst = 1'b1;
        cycle();

        $display("[TB] single event");
        applyStimulus(8'h05, 32'h1234_5678);
        checkOutput("t1Valid", 32'(dbgnoc_out_valid), 32'd0);
        checkOutput("t1Level", 32'(fifo_level),       32'd1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            checkOutput("singleFlit", 32'(dbgnoc_out_flit), 32'(singleReq[i]));
        end
        cycle();
        checkOutput("singleEnd", 32'(dbgnoc_out_valid), 32'd0);

        $display("[TB] backpressure");
        applyStimulus(8'hA7, 32'hDEAD_BEEF);
        for (int i = 0; i < 20 && !(mActive && mIdx == 3); i++) cycle();
        checkOutput("bpReachTsh", 32'(dbgnoc_out_flit), 32'h0DEAD);
        dbgnoc_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkOutput("bpHoldFlit",  32'(dbgnoc_out_flit),  32'h0DEAD);
            checkOutput("bpHoldValid", 32'(dbgnoc_out_valid), 32'd1);
        end
        dbgnoc_out_ready = 1'b1;
        cycle();
        checkOutput("bpAccept", 32'(dbgnoc_out_flit), 32'h2BEEF);
        drain();

        $display("[TB] overflow");
        dbgnoc_out_ready = 1'b0;
        for (int i = 0; i < 7; i++) applyStimulus(8'(i), $urandom);
        checkOutput("ovfLevel", 32'(fifo_level), 32'd4);
        checkOutput("ovfDrop",  32'(drop_count), 32'd2);
        dbgnoc_out_ready = 1'b1;
        n = 0;
        for (int i = 0; i < 100 && (mActive || q.size() > 0); i++) begin
            cycle();
            if (mActive && mIdx == 2) begin
                idReq = {2'b00, (n == 0) ? 8'h02 : 8'h00, 8'(n)};
                checkOutput("ovfIdFlit", 32'(dbgnoc_out_flit), 32'(idReq));
                if (n == 0) checkOutput("ovfDropClr", 32'(drop_count), 32'd0);
                n++;
            end
        end
        checkOutput("ovfPackets", 32'(n), 32'd5);

        $display("[TB] back-to-back");
        applyStimulus(8'($urandom), $urandom);
        applyStimulus(8'($urandom), $urandom);
        for (int i = 0; i < 10; i++) begin
            checkOutput("b2bValid", 32'(dbgnoc_out_valid),       32'd1);
            checkOutput("b2bType",  32'(dbgnoc_out_flit[17:16]), 32'(typeReq[i % 5]));
            cycle();
        end
        checkOutput("b2bIdle", 32'(dbgnoc_out_valid), 32'd0);

        $display("[TB] enable low");
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'($urandom), $urandom);
            cycle();
            checkOutput("enLowValid", 32'(dbgnoc_out_valid), 32'd0);
        end
        checkOutput("enLowLevel", 32'(fifo_level), 32'd0);
        checkOutput("enLowDrop",  32'(drop_count), 32'd0);
        enable = 1'b1;

        $display("[TB] random traffic");
        for (int i = 0; i < 500; i++) begin
            ev_valid         = ($urandom_range(0, 2) == 0);
            ev_id            = 8'($urandom);
            ev_time          = $urandom;
            enable           = ($urandom_range(0, 9) != 0);
            dbgnoc_out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        ev_valid = 1'b0; enable = 1'b1; dbgnoc_out_ready = 1'b1;
        drain();

        $display("[TB] reset mid-packet");
        dbgnoc_out_ready = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus(8'(8'h40 + i), $urandom);
        dbgnoc_out_ready = 1'b1;
        for (int i = 0; i < 20 && !(mActive && mIdx == 2); i++) cycle();
        rst = 1'b0;
        cycle();
        checkOutput("midRstValid", 32'(dbgnoc_out_valid), 32'd0);
        checkOutput("midRstFlit",  32'(dbgnoc_out_flit),  32'd0);
        checkOutput("midRstLevel", 32'(fifo_level),       32'd0);
        checkOutput("midRstDrop",  32'(drop_count),       32'd0);
        rst = 1'b1;
        cycle();
        applyStimulus(8'h3C, 32'hCAFE_0001);
        for (int i = 0; i < 10 && !mActive; i++) cycle();
        checkOutput("postRstHdr", 32'(dbgnoc_out_flit), 32'h10010);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
